// File: rtl/difftest_csr_sync_ctrl.sv
// Shadow CSR collector for difftest: round-robin serialises CSR writes from commit-side
// requesters and publishes one frozen snapshot per closed commit group over valid/ready.
module difftest_csr_sync_ctrl #(
    parameter int NREQ    = 3,
    parameter int XLEN    = 76,
    parameter int NCSR    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*4-1:0]      req_idx,
    input  logic [NREQ*XLEN-1:0]   req_data,
    input  logic [NREQ-1:0]        req_last,
    input  logic [1:0]             priv_in,
    output logic                   snap_valid,
    input  logic                   snap_ready,
    output logic [NCSR*XLEN-1:0]   snap_csrs,
    output logic [1:0]             snap_priv,
    output logic [7:0]             snap_seq,
    output logic                   err_sticky
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TCW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTRW-1:0]   rr_ptr;
    logic [TCW-1:0]    tcnt;
    logic [XLEN-1:0]   shadow [NCSR];

    logic [3:0]        idx_a  [NREQ];
    logic [XLEN-1:0]   data_a [NREQ];

    logic [PTRW-1:0]   gsel;
    logic [PTRW-1:0]   cand;
    logic              found;
    logic [3:0]        cur_idx;
    logic [XLEN-1:0]   cur_data;
    logic              cur_last;
    logic              accept;
    logic              accept_last;
    logic              idx_ok;
    logic              timeout;

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign idx_a[r]  = req_idx[r*4 +: 4];
        assign data_a[r] = req_data[r*XLEN +: XLEN];
    end

    for (genvar k = 0; k < NCSR; k++) begin : g_snap
        assign snap_csrs[k*XLEN +: XLEN] = shadow[k];
    end

    // Grant the first valid requester at or after the pointer; nothing is granted while a
    // snapshot is pending so the shadow file cannot change under the sink.
    always_comb begin
        req_ready = '0;
        gsel      = '0;
        cand      = '0;
        found     = 1'b0;
        cur_idx   = '0;
        cur_data  = '0;
        cur_last  = 1'b0;
        if (state != EMIT) begin
            for (int off = 0; off < NREQ; off++) begin
                cand = PTRW'((int'(rr_ptr) + off) % NREQ);
                if (!found && req_valid[cand]) begin
                    found           = 1'b1;
                    req_ready[cand] = 1'b1;
                    gsel            = cand;
                    cur_idx         = idx_a[cand];
                    cur_data        = data_a[cand];
                    cur_last        = req_last[cand];
                end
            end
        end
    end

    assign accept      = |req_ready;
    assign accept_last = accept && cur_last;
    assign idx_ok      = {28'b0, cur_idx} < 32'(NCSR);
    assign timeout     = (state == COLLECT) && (tcnt == TCW'(TIMEOUT - 1)) && !accept_last;
    assign snap_valid  = (state == EMIT);

    // A last beat closes the group; a timeout force-closes it when the last beat never comes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_last)
                    state_nxt = EMIT;
                else if (accept)
                    state_nxt = COLLECT;
            end
            COLLECT: begin
                if (accept_last || timeout)
                    state_nxt = EMIT;
            end
            EMIT: begin
                if (snap_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            tcnt       <= '0;
            snap_priv  <= 2'b11;
            snap_seq   <= 8'd0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                rr_ptr <= (gsel == PTRW'(NREQ - 1)) ? '0 : gsel + 1'b1;
            if (state == COLLECT && state_nxt == COLLECT)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
            if (accept_last)
                snap_priv <= priv_in;
            if (state == EMIT && snap_ready)
                snap_seq <= snap_seq + 8'd1;
            if ((accept && !idx_ok) || timeout)
                err_sticky <= 1'b1;
        end
    end

    // Out-of-range indices match no entry here, so their data is silently dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCSR; k++)
                shadow[k] <= '0;
        end else begin
            for (int k = 0; k < NCSR; k++)
                if (accept && cur_idx == 4'(k))
                    shadow[k] <= cur_data;
        end
    end

endmodule

// File: tb/tb_difftest_csr_sync_ctrl.sv
// Scoreboard bench for difftest_csr_sync_ctrl: expected snapshots are queued as beats are
// driven and compared when the DUT presents them.
module tb_difftest_csr_sync_ctrl;

    localparam int NREQ    = 3;
    localparam int XLEN    = 76;
    localparam int NCSR    = 12;
    localparam int TIMEOUT = 64;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*4-1:0]     req_idx;
    logic [NREQ*XLEN-1:0]  req_data;
    logic [NREQ-1:0]       req_last;
    logic [1:0]            priv_in;
    logic                  snap_valid;
    logic                  snap_ready;
    logic [NCSR*XLEN-1:0]  snap_csrs;
    logic [1:0]            snap_priv;
    logic [7:0]            snap_seq;
    logic                  err_sticky;

    difftest_csr_sync_ctrl #(
        .NREQ(NREQ), .XLEN(XLEN), .NCSR(NCSR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_data(req_data), .req_last(req_last), .priv_in(priv_in),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_csrs(snap_csrs),
        .snap_priv(snap_priv), .snap_seq(snap_seq), .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NCSR*XLEN-1:0] csrs;
        logic [1:0]           priv;
        logic [7:0]           seq;
    } snap_t;

    snap_t           exp_q[$];
    snap_t           exp_s;
    logic [XLEN-1:0] model_csr [NCSR];
    logic [1:0]      model_priv;
    logic [7:0]      model_seq;
    logic [NREQ-1:0] seen_ready;
    int              vectors = 0;
    int              miscompares = 0;

    task automatic push_snap();
        snap_t s;
        for (int k = 0; k < NCSR; k++)
            s.csrs[k*XLEN +: XLEN] = model_csr[k];
        s.priv = model_priv;
        s.seq  = model_seq;
        exp_q.push_back(s);
        model_seq = model_seq + 8'd1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_idx   = '0;
        req_data  = '0;
        req_last  = '0;
        priv_in   = 2'b00;
    endtask

    task automatic model_init();
        for (int k = 0; k < NCSR; k++)
            model_csr[k] = '0;
        model_priv = 2'b11;
        model_seq  = 8'd0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        clear_inputs();
        snap_ready = 1'b0;
        reset = 1'b1;
        model_init();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Drives one beat from a single requester for one cycle and updates the model as accepted.
    task automatic send(input int r, input logic [3:0] idx, input logic [XLEN-1:0] data,
                        input logic last, input logic [1:0] priv);
        clear_inputs();
        req_valid[r]             = 1'b1;
        req_idx[r*4 +: 4]        = idx;
        req_data[r*XLEN +: XLEN] = data;
        req_last[r]              = last;
        priv_in                  = priv;
        #1 seen_ready = req_ready;
        if (int'(idx) < NCSR)
            model_csr[int'(idx)] = data;
        if (last) begin
            model_priv = priv;
            push_snap();
        end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic ack();
        snap_ready = 1'b1;
        @(negedge clock);
        snap_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        snap_ready = 1'b0;
        reset = 1'b1;
        model_init();
        @(negedge clock);
        vectors++;
        if (snap_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rst_valid: got %b expected 0", snap_valid);
        end
        vectors++;
        if (snap_priv !== 2'b11) begin
            miscompares++; $display("[TB] FAIL rst_priv: got %b expected 11", snap_priv);
        end
        vectors++;
        if (snap_seq !== 8'd0) begin
            miscompares++; $display("[TB] FAIL rst_seq: got %0d expected 0", snap_seq);
        end
        vectors++;
        if (err_sticky !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rst_err: got %b expected 0", err_sticky);
        end
        vectors++;
        if (snap_csrs !== '0) begin
            miscompares++; $display("[TB] FAIL rst_csrs: got nonzero shadow, expected all zero");
        end
        req_valid = 3'b111;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++; $display("[TB] FAIL rst_grant: got %b expected 001", req_ready);
        end
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_beat();
        send(0, 4'd4, 76'hAB, 1'b1, 2'b01);
        vectors++;
        if (seen_ready !== 3'b001) begin
            miscompares++; $display("[TB] FAIL t1_grant: got %b expected 001", seen_ready);
        end
        vectors++;
        if (snap_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL t1_valid: got %b expected 1", snap_valid);
        end
        vectors++;
        if (snap_csrs[4*XLEN +: XLEN] !== 76'hAB) begin
            miscompares++; $display("[TB] FAIL t1_mcause: got %h expected ab", snap_csrs[4*XLEN +: XLEN]);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL t1_snap: got no queued snapshot, expected one");
        end else begin
            exp_s = exp_q.pop_front();
            if (snap_csrs !== exp_s.csrs || snap_priv !== exp_s.priv || snap_seq !== exp_s.seq) begin
                miscompares++;
                $display("[TB] FAIL t1_snap: got priv=%0d seq=%0d csrs_ok=%0d, expected priv=%0d seq=%0d",
                         snap_priv, snap_seq, snap_csrs === exp_s.csrs, exp_s.priv, exp_s.seq);
            end
        end
        ack();
        vectors++;
        if (snap_valid !== 1'b0 || snap_seq !== 8'd1) begin
            miscompares++; $display("[TB] FAIL t1_ack: got valid=%b seq=%0d expected valid=0 seq=1", snap_valid, snap_seq);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_grant;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_valid = 3'b111;
            req_last  = '0;
            for (int r = 0; r < NREQ; r++) begin
                req_idx[r*4 +: 4]        = 4'(r);
                req_data[r*XLEN +: XLEN] = {12'h5C0, 32'(c), 32'(r)};
            end
            #1;
            exp_grant = 3'b001 << (c % 3);
            vectors++;
            if (req_ready !== exp_grant) begin
                miscompares++; $display("[TB] FAIL t2_grant%0d: got %b expected %b", c, req_ready, exp_grant);
            end
            model_csr[c % 3] = {12'h5C0, 32'(c), 32'(c % 3)};
            @(negedge clock);
        end
        clear_inputs();
        send(0, 4'd5, 76'h1234, 1'b1, 2'b10);
        vectors++;
        if (snap_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL t2_valid: got %b expected 1", snap_valid);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL t2_snap: got no queued snapshot, expected one");
        end else begin
            exp_s = exp_q.pop_front();
            if (snap_csrs !== exp_s.csrs || snap_priv !== exp_s.priv || snap_seq !== exp_s.seq) begin
                miscompares++;
                $display("[TB] FAIL t2_snap: got priv=%0d seq=%0d csrs_ok=%0d, expected priv=%0d seq=%0d",
                         snap_priv, snap_seq, snap_csrs === exp_s.csrs, exp_s.priv, exp_s.seq);
            end
        end
        ack();
    endtask

    task automatic test_hold();
        logic [NCSR*XLEN-1:0] held;
        send(1, 4'd9, 76'hF00D, 1'b1, 2'b00);
        held = '0;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL t3_snap: got no queued snapshot, expected one");
        end else begin
            exp_s = exp_q.pop_front();
            held  = exp_s.csrs;
            if (snap_csrs !== exp_s.csrs || snap_priv !== exp_s.priv || snap_seq !== exp_s.seq) begin
                miscompares++;
                $display("[TB] FAIL t3_snap: got priv=%0d seq=%0d csrs_ok=%0d, expected priv=%0d seq=%0d",
                         snap_priv, snap_seq, snap_csrs === exp_s.csrs, exp_s.priv, exp_s.seq);
            end
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = 3'b111;
            req_idx   = {4'd1, 4'd2, 4'd3};
            req_data  = {3{76'h777}};
            #1;
            vectors++;
            if (req_ready !== 3'b000 || snap_valid !== 1'b1 || snap_csrs !== held) begin
                miscompares++;
                $display("[TB] FAIL t3_hold%0d: got ready=%b valid=%b csrs_ok=%0d expected ready=000 valid=1 csrs_ok=1",
                         c, req_ready, snap_valid, snap_csrs === held);
            end
            @(negedge clock);
        end
        clear_inputs();
        ack();
        vectors++;
        if (snap_valid !== 1'b0 || snap_seq !== model_seq) begin
            miscompares++; $display("[TB] FAIL t3_release: got valid=%b seq=%0d expected valid=0 seq=%0d", snap_valid, snap_seq, model_seq);
        end
        req_valid = 3'b100;
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin
            miscompares++; $display("[TB] FAIL t3_regrant: got %b expected 100", req_ready);
        end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_bad_index();
        vectors++;
        if (err_sticky !== 1'b0) begin
            miscompares++; $display("[TB] FAIL t4_pre_err: got %b expected 0", err_sticky);
        end
        send(2, 4'd13, 76'hBAD, 1'b0, 2'b00);
        vectors++;
        if (seen_ready !== 3'b100 || err_sticky !== 1'b1) begin
            miscompares++; $display("[TB] FAIL t4_bad_idx: got ready=%b err=%b expected ready=100 err=1", seen_ready, err_sticky);
        end
        send(0, 4'd2, 76'hC0FFEE, 1'b1, 2'b01);
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL t4_snap: got no queued snapshot, expected one");
        end else begin
            exp_s = exp_q.pop_front();
            if (snap_valid !== 1'b1 || snap_csrs !== exp_s.csrs || snap_priv !== exp_s.priv || snap_seq !== exp_s.seq) begin
                miscompares++;
                $display("[TB] FAIL t4_snap: got valid=%b priv=%0d seq=%0d csrs_ok=%0d, expected valid=1 priv=%0d seq=%0d",
                         snap_valid, snap_priv, snap_seq, snap_csrs === exp_s.csrs, exp_s.priv, exp_s.seq);
            end
        end
        ack();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        send(0, 4'd7, 76'h7777, 1'b0, 2'b10);
        push_snap();
        n = 0;
        while (snap_valid !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (n != TIMEOUT) begin
            miscompares++; $display("[TB] FAIL t5_latency: got %0d cycles expected %0d", n, TIMEOUT);
        end
        vectors++;
        if (err_sticky !== 1'b1 || snap_priv !== 2'b11) begin
            miscompares++; $display("[TB] FAIL t5_err_priv: got err=%b priv=%b expected err=1 priv=11", err_sticky, snap_priv);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL t5_snap: got no queued snapshot, expected one");
        end else begin
            exp_s = exp_q.pop_front();
            if (snap_csrs !== exp_s.csrs || snap_priv !== exp_s.priv || snap_seq !== exp_s.seq) begin
                miscompares++;
                $display("[TB] FAIL t5_snap: got priv=%0d seq=%0d csrs_ok=%0d, expected priv=%0d seq=%0d",
                         snap_priv, snap_seq, snap_csrs === exp_s.csrs, exp_s.priv, exp_s.seq);
            end
        end
        ack();
    endtask

    task automatic test_timeout_race();
        do_reset();
        send(1, 4'd3, 76'h3333, 1'b0, 2'b00);
        repeat (TIMEOUT - 1) @(negedge clock);
        vectors++;
        if (snap_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL race_early: got valid=%b expected 0", snap_valid);
        end
        send(1, 4'd6, 76'h6666, 1'b1, 2'b01);
        vectors++;
        if (snap_valid !== 1'b1 || err_sticky !== 1'b0 || snap_priv !== 2'b01) begin
            miscompares++; $display("[TB] FAIL race_last: got valid=%b err=%b priv=%b expected valid=1 err=0 priv=01",
                                    snap_valid, err_sticky, snap_priv);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL race_snap: got no queued snapshot, expected one");
        end else begin
            exp_s = exp_q.pop_front();
            if (snap_csrs !== exp_s.csrs || snap_seq !== exp_s.seq) begin
                miscompares++; $display("[TB] FAIL race_snap: got seq=%0d csrs_ok=%0d expected seq=%0d", snap_seq, snap_csrs === exp_s.csrs, exp_s.seq);
            end
        end
        ack();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(i % NREQ, 4'(i % NCSR), {12'hE00, 32'(i * 7), 32'(i)}, 1'b1, 2'(i));
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("[TB] FAIL t6_snap%0d: got no queued snapshot, expected one", i);
            end else begin
                exp_s = exp_q.pop_front();
                if (snap_valid !== 1'b1 || snap_csrs !== exp_s.csrs || snap_priv !== exp_s.priv || snap_seq !== exp_s.seq) begin
                    miscompares++;
                    $display("[TB] FAIL t6_snap%0d: got valid=%b priv=%0d seq=%0d csrs_ok=%0d, expected valid=1 priv=%0d seq=%0d",
                             i, snap_valid, snap_priv, snap_seq, snap_csrs === exp_s.csrs, exp_s.priv, exp_s.seq);
                end
            end
            ack();
        end
        vectors++;
        if (snap_seq !== 8'd0) begin
            miscompares++; $display("[TB] FAIL t6_wrap: got seq=%0d expected 0", snap_seq);
        end
        send(0, 4'd1, 76'h1, 1'b1, 2'b11);
        vectors++;
        if (snap_valid !== 1'b1) begin
            miscompares++; $display("[TB] FAIL t6_pre_rst: got valid=%b expected 1", snap_valid);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (snap_valid !== 1'b0 || snap_seq !== 8'd0 || snap_csrs !== '0) begin
            miscompares++; $display("[TB] FAIL t6_mid_rst: got valid=%b seq=%0d csrs_zero=%0d expected valid=0 seq=0 csrs_zero=1",
                                    snap_valid, snap_seq, snap_csrs === '0);
        end
        model_init();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        snap_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_single_beat();
        test_round_robin();
        test_hold();
        test_bad_index();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
